// File: rtl/regfile_sched.sv
// regfile_sched: arbitrates a two-operand reader and a queued single writer onto
// one register-file port, with write forwarding and read-starvation control.
module regfile_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [2:0]  rd_a,
  input  logic [2:0]  rd_b,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  input  logic        wb_req,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        wb_ready,
  output logic        rf_readflag,
  output logic [2:0]  rf_rs,
  output logic [2:0]  rf_rd,
  output logic [15:0] rf_value,
  input  logic [15:0] rf_read1,
  input  logic [15:0] rf_read2,
  output logic        busy
);

  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE} op_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0]  q_addr   [2];
  logic [15:0] q_data   [2];
  logic [2:0]  q_addr_n [2];
  logic [15:0] q_data_n [2];
  logic [1:0]  q_cnt, q_cnt_n;
  logic [3:0]  starve, starve_n;
  logic        force_drain, push, pop, slot;
  op_e         op;
  logic        hit_a, hit_b, fwd_hit_a, fwd_hit_b;
  logic [15:0] hdata_a, hdata_b, fwd_a, fwd_b;

  assign force_drain = (q_cnt == 2'd2) || ((starve == LIMIT) && (q_cnt != 2'd0));
  assign rd_ready    = reset_n && !force_drain;
  assign wb_ready    = reset_n && (q_cnt != 2'd2);
  assign busy        = (q_cnt != 2'd0);
  assign push        = wb_req && wb_ready;

  // Reads win the port unless the queue has forced a drain.
  always_comb begin
    op = OP_IDLE;
    if (reset_n) begin
      if (rd_req && !force_drain)
        op = OP_READ;
      else if (q_cnt != 2'd0)
        op = OP_WRITE;
    end
  end

  assign pop = (op == OP_WRITE);

  always_comb begin
    rf_readflag = 1'b1;
    rf_rs       = 3'd0;
    rf_rd       = 3'd0;
    rf_value    = 16'd0;
    case (op)
      OP_READ: begin
        rf_rs = rd_a;
        rf_rd = rd_b;
      end
      OP_WRITE: begin
        rf_readflag = 1'b0;
        rf_rs       = q_addr[0];
        rf_value    = q_data[0];
      end
      default: ;
    endcase
  end

  // Entry 1 is always the newer one, so it overrides a match in entry 0.
  always_comb begin
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    hdata_a = 16'd0;
    hdata_b = 16'd0;
    if (q_cnt != 2'd0 && q_addr[0] == rd_a) begin
      hit_a   = 1'b1;
      hdata_a = q_data[0];
    end
    if (q_cnt == 2'd2 && q_addr[1] == rd_a) begin
      hit_a   = 1'b1;
      hdata_a = q_data[1];
    end
    if (q_cnt != 2'd0 && q_addr[0] == rd_b) begin
      hit_b   = 1'b1;
      hdata_b = q_data[0];
    end
    if (q_cnt == 2'd2 && q_addr[1] == rd_b) begin
      hit_b   = 1'b1;
      hdata_b = q_data[1];
    end
  end

  // A simultaneous pop shifts the tail down, so the push lands in slot 0.
  always_comb begin
    q_addr_n = q_addr;
    q_data_n = q_data;
    slot     = pop ? 1'b0 : q_cnt[0];
    if (pop) begin
      q_addr_n[0] = q_addr[1];
      q_data_n[0] = q_data[1];
    end
    if (push) begin
      q_addr_n[slot] = wb_addr;
      q_data_n[slot] = wb_data;
    end
    q_cnt_n = q_cnt + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    starve_n = starve;
    if (pop || q_cnt == 2'd0)
      starve_n = 4'd0;
    else if (op == OP_READ && starve != LIMIT)
      starve_n = starve + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_addr[0] <= 3'd0;
      q_addr[1] <= 3'd0;
      q_data[0] <= 16'd0;
      q_data[1] <= 16'd0;
      q_cnt     <= 2'd0;
      starve    <= 4'd0;
      rd_valid  <= 1'b0;
      fwd_hit_a <= 1'b0;
      fwd_hit_b <= 1'b0;
      fwd_a     <= 16'd0;
      fwd_b     <= 16'd0;
    end else begin
      q_addr   <= q_addr_n;
      q_data   <= q_data_n;
      q_cnt    <= q_cnt_n;
      starve   <= starve_n;
      rd_valid <= (op == OP_READ);
      if (op == OP_READ) begin
        fwd_hit_a <= hit_a;
        fwd_hit_b <= hit_b;
        fwd_a     <= hdata_a;
        fwd_b     <= hdata_b;
      end
    end
  end

  assign rd_data_a = fwd_hit_a ? fwd_a : rf_read1;
  assign rd_data_b = fwd_hit_b ? fwd_b : rf_read2;

endmodule

// File: tb/tb_regfile_sched.sv
// Bench for regfile_sched: directed per-cycle vectors, a register-file model,
// and a scoreboard monitor that checks every read result against expectations.
module tb_regfile_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_req, wb_req;
  logic [2:0]  rd_a, rd_b, wb_addr;
  logic [15:0] wb_data;
  logic        rd_ready, rd_valid, wb_ready, rf_readflag, busy;
  logic [15:0] rd_data_a, rd_data_b, rf_value;
  logic [2:0]  rf_rs, rf_rd;
  logic [15:0] rf_read1 = 16'd0, rf_read2 = 16'd0;

  logic [15:0] regs [8];
  logic [15:0] exp_a, exp_b;
  logic [31:0] sb [$];
  logic [18:0] wr_log [$];
  int          n_chk = 0;
  int          n_fail = 0;

  regfile_sched #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req(rd_req), .rd_a(rd_a), .rd_b(rd_b), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_readflag(rf_readflag), .rf_rs(rf_rs), .rf_rd(rf_rd), .rf_value(rf_value),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .busy(busy)
  );

  always #5 clock = ~clock;

  initial for (int i = 0; i < 8; i++) regs[i] = 16'hC000 + 16'(i);

  // Register file with registered read ports.
  always @(posedge clock) begin
    if (!rf_readflag) regs[rf_rs] <= rf_value;
    rf_read1 <= regs[rf_rs];
    rf_read2 <= regs[rf_rd];
  end

  always @(posedge clock) begin
    if (reset_n && !rf_readflag) wr_log.push_back({rf_rs, rf_value});
    if (reset_n && rd_req && rd_ready) sb.push_back({exp_a, exp_b});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        automatic logic [31:0] e = sb.pop_front();
        check("rd_data", {rd_data_a, rd_data_b}, e);
      end
    end
  end

  task automatic row(input logic rd, input logic [2:0] a, input logic [2:0] b,
                     input logic wb, input logic [2:0] wa, input logic [15:0] wd,
                     input logic rdy, input logic wrdy, input logic bsy,
                     input logic [15:0] ea, input logic [15:0] eb);
    @(negedge clock);
    rd_req = rd; rd_a = a; rd_b = b;
    wb_req = wb; wb_addr = wa; wb_data = wd;
    exp_a = ea; exp_b = eb;
    #1;
    check("rd_ready", 32'(rd_ready), 32'(rdy));
    check("wb_ready", 32'(wb_ready), 32'(wrdy));
    check("busy", 32'(busy), 32'(bsy));
    if (!rd && !bsy)
      check("idle_op", {rf_readflag, 9'd0, rf_rs, rf_rd, rf_value}, 32'h8000_0000);
    if (!rdy || (!rd && bsy))
      check("write_op", 32'(rf_readflag), 32'd0);
  endtask

  task automatic idle(input logic bsy);
    row(0, 0, 0, 0, 0, 16'h0, 1, 1, bsy, 16'h0, 16'h0);
  endtask

  logic [18:0] exp_wr [7];

  initial begin
    exp_wr = '{{3'd3, 16'h1234}, {3'd1, 16'hAAAA}, {3'd2, 16'hBBBB}, {3'd6, 16'h6666},
               {3'd5, 16'h0001}, {3'd5, 16'h0002}, {3'd4, 16'h4444}};
    exp_a = 16'h0; exp_b = 16'h0;
    reset_n = 1'b0;
    rd_req = 1'b1; rd_a = 3'd3; rd_b = 3'd5;
    wb_req = 1'b1; wb_addr = 3'd2; wb_data = 16'hFFFF;
    repeat (2) @(negedge clock);
    #1;
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rf", {rf_readflag, 9'd0, rf_rs, rf_rd, rf_value}, 32'h8000_0000);
    @(negedge clock);
    reset_n = 1'b1;
    rd_req = 1'b0; wb_req = 1'b0; rd_a = 3'd0; rd_b = 3'd0; wb_addr = 3'd0; wb_data = 16'h0;
    #1;
    check("rel_rd_ready", 32'(rd_ready), 32'd1);
    check("rel_wb_ready", 32'(wb_ready), 32'd1);

    // Write drains in the next cycle, read then sees it in the register file.
    row(0, 0, 0, 1, 3, 16'h1234, 1, 1, 0, 16'h0, 16'h0);
    idle(1);
    row(1, 3, 3, 0, 0, 16'h0, 1, 1, 0, 16'h1234, 16'h1234);
    idle(0);

    // Reads held high while two writes queue: full drain, then starvation drain.
    row(1, 1, 2, 1, 1, 16'hAAAA, 1, 1, 0, 16'hC001, 16'hC002);
    row(1, 1, 2, 1, 2, 16'hBBBB, 1, 1, 1, 16'hAAAA, 16'hC002);
    row(1, 1, 2, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0);
    repeat (4) row(1, 1, 2, 0, 0, 16'h0, 1, 1, 1, 16'hAAAA, 16'hBBBB);
    row(1, 1, 2, 0, 0, 16'h0, 0, 1, 1, 16'h0, 16'h0);
    row(1, 1, 2, 0, 0, 16'h0, 1, 1, 0, 16'hAAAA, 16'hBBBB);
    idle(0);

    // One queued write: exactly four reads, one forced write, reads resume.
    row(0, 0, 0, 1, 6, 16'h6666, 1, 1, 0, 16'h0, 16'h0);
    repeat (4) row(1, 6, 7, 0, 0, 16'h0, 1, 1, 1, 16'h6666, 16'hC007);
    row(1, 6, 7, 0, 0, 16'h0, 0, 1, 1, 16'h0, 16'h0);
    repeat (2) row(1, 6, 7, 0, 0, 16'h0, 1, 1, 0, 16'h6666, 16'hC007);
    idle(0);

    // Duplicate r5 writes: forwarding returns the newer value over the file.
    row(1, 0, 0, 1, 5, 16'h0001, 1, 1, 0, 16'hC000, 16'hC000);
    row(1, 5, 0, 1, 5, 16'h0002, 1, 1, 1, 16'h0001, 16'hC000);
    row(1, 5, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0, 16'h0);
    row(1, 5, 0, 0, 0, 16'h0, 1, 1, 1, 16'h0002, 16'hC000);
    idle(1);
    row(1, 5, 5, 0, 0, 16'h0, 1, 1, 0, 16'h0002, 16'h0002);
    idle(0);

    // Write accepted with a same-cycle read: old value, then new value.
    row(1, 4, 4, 1, 4, 16'h4444, 1, 1, 0, 16'hC004, 16'hC004);
    row(1, 4, 4, 0, 0, 16'h0, 1, 1, 1, 16'h4444, 16'h4444);
    idle(1);
    row(1, 4, 0, 0, 0, 16'h0, 1, 1, 0, 16'h4444, 16'hC000);
    idle(0);

    // Reset with a full queue and a read in flight.
    row(1, 7, 0, 1, 7, 16'h7777, 1, 1, 0, 16'hC007, 16'hC000);
    row(1, 0, 7, 1, 0, 16'h0F0F, 1, 1, 1, 16'hC000, 16'h7777);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    rd_req = 1'b0; wb_req = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rd_ready", 32'(rd_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    idle(0);
    row(1, 7, 0, 0, 0, 16'h0, 1, 1, 0, 16'hC007, 16'hC000);
    repeat (3) idle(0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("wr_log_size", 32'(wr_log.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("wr_log_%0d", i),
            (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hDEAD_BEEF, 32'(exp_wr[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
